// File: rtl/stream_range_pkg.sv
// Shared types for the stream_range source: FSM state encoding and default widths.
package stream_range_pkg;

  localparam int unsigned STREAM_RANGE_N     = 8;
  localparam int unsigned STREAM_RANGE_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/stream_range.sv
// Stream source: accepts (start, count, step) and emits count elements
// start, start+step, ... on a valid/ready stream, then signals completion.
module stream_range
  import stream_range_pkg::*;
#(
  parameter int unsigned N     = STREAM_RANGE_N,
  parameter int unsigned CNT_W = STREAM_RANGE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     start,
  input  logic [CNT_W-1:0] count,
  input  logic [N-1:0]     step,
  output logic [N-1:0]     sOut,
  output logic             sOut_valid,
  input  logic             sOut_ready,
  output logic             sOut_last,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e           state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  logic [N-1:0]     step_q, step_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      step_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          step_d      = step;
          data_d      = start;
          remaining_d = count;
          state_d     = (count != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (sOut_ready) begin
          data_d      = data_q + step_q;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stream valid is exactly "in RUN", so data and last hold naturally under backpressure.
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    sOut_valid = (state_q == ST_RUN);
    sOut_last  = (state_q == ST_RUN) && (remaining_q == CNT_W'(1));
    out_valid  = (state_q == ST_DONE);
    sOut       = data_q;
  end

endmodule

// File: tb/tb_stream_range.sv
// Randomized self-checking bench for stream_range against an arithmetic reference.
module tb_stream_range;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] start;
  logic [7:0] count;
  logic [7:0] step;
  logic [7:0] sOut;
  logic       sOut_valid;
  logic       sOut_ready;
  logic       sOut_last;
  logic       out_valid;
  logic       out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_range #(.N(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .count(count), .step(step),
    .sOut(sOut), .sOut_valid(sOut_valid), .sOut_ready(sOut_ready), .sOut_last(sOut_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_elem(input int s, input int st, input int i);
    return 8'((s + i * st) % 256);
  endfunction

  // ready_pct: chance (0..100) that the consumer is ready on a cycle;
  // hold_done: cycles out_ready stays low in DONE; noise: drive junk commands during the burst.
  task automatic run_cmd(input int s, input int c, input int st, input int ready_pct,
                         input int hold_done, input bit noise, input string tag);
    int idx;
    int budget;
    @(negedge clk);
    check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; start = 8'(s); count = 8'(c); step = 8'(st);
    @(negedge clk);
    idx = 0;
    budget = 0;
    while (idx < c && budget < 4000) begin
      if (noise) begin
        in_valid = 1'($urandom); start = 8'($urandom); count = 8'($urandom); step = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      check({tag, ".valid"}, 32'(sOut_valid), 32'd1);
      check({tag, ".data"},  32'(sOut), 32'(ref_elem(s, st, idx)));
      check({tag, ".last"},  32'(sOut_last), 32'(idx == c - 1));
      check({tag, ".busy"},  32'({in_ready, out_valid}), 32'd0);
      sOut_ready = ($urandom_range(99) < 32'(ready_pct));
      if (sOut_ready) idx++;
      budget++;
      @(negedge clk);
    end
    if (budget >= 4000) check({tag, ".timeout"}, 32'(idx), 32'(c));
    sOut_ready = 1'($urandom);
    if (!noise) in_valid = 1'b0;
    for (int k = 0; k < hold_done; k++) begin
      check({tag, ".done_valid"}, 32'({sOut_valid, out_valid, in_ready}), 32'b010);
      @(negedge clk);
    end
    check({tag, ".done_valid"}, 32'({sOut_valid, out_valid, in_ready}), 32'b010);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    sOut_ready = 1'b0;
    check({tag, ".back_idle"}, 32'({sOut_valid, out_valid, in_ready}), 32'b001);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; start = '0; count = '0; step = '0;
    sOut_ready = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.outs", 32'({sOut_valid, sOut_last, out_valid, in_ready}), 32'b0001);
    check("reset.sout", 32'(sOut), 32'd0);
    rst = 1'b0;

    run_cmd(0, 5, 1, 100, 0, 1'b0, "t1");
    run_cmd(250, 8, 3, 100, 0, 1'b0, "t2");

    // Directed backpressure pattern 1,0,0,1,1.
    @(negedge clk);
    in_valid = 1'b1; start = 8'd10; count = 8'd3; step = 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    begin
      logic [4:0] pat;
      logic [7:0] exp_d [5];
      pat = 5'b11001;
      exp_d = '{8'd10, 8'd11, 8'd11, 8'd11, 8'd12};
      for (int k = 0; k < 5; k++) begin
        check("t3.data", 32'({sOut_valid, sOut}), 32'({1'b1, exp_d[k]}));
        check("t3.last", 32'(sOut_last), 32'(k == 4));
        sOut_ready = pat[k];
        @(negedge clk);
      end
      sOut_ready = 1'b0;
      check("t3.done", 32'({sOut_valid, out_valid}), 32'b01);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("t3.idle", 32'(in_ready), 32'd1);
    end

    run_cmd(9, 0, 4, 100, 0, 1'b0, "t4");

    // Reset in the middle of a count=6 burst.
    @(negedge clk);
    in_valid = 1'b1; start = 8'd0; count = 8'd6; step = 8'd1;
    @(negedge clk);
    in_valid = 1'b0; sOut_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t5.pre", 32'({sOut_valid, sOut}), 32'({1'b1, 8'd2}));
    sOut_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5.after_rst", 32'({sOut_valid, out_valid, in_ready}), 32'b001);
    repeat (3) begin
      @(negedge clk);
      check("t5.quiet", 32'({sOut_valid, out_valid}), 32'd0);
    end
    run_cmd(7, 2, 1, 100, 0, 1'b0, "t5b");

    run_cmd(100, 4, 5, 100, 3, 1'b1, "t6");

    run_cmd(1, 255, 1, 90, 1, 1'b1, "max");

    for (int r = 0; r < 40; r++) begin
      run_cmd(int'($urandom_range(255)), int'($urandom_range(20)), int'($urandom_range(255)),
              int'($urandom_range(100, 20)), int'($urandom_range(3)), 1'($urandom), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
